// File: rtl/baccarat_pkg.sv
// Shared types, card codes and helpers for the baccarat hand controller.
package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1  = 4'd0,
    DEAL_D1  = 4'd1,
    DEAL_P2  = 4'd2,
    DEAL_D2  = 4'd3,
    CHK_NAT  = 4'd4,
    DEAL_P3  = 4'd5,
    CHK_BANK = 4'd6,
    DEAL_D3  = 4'd7,
    RESULT   = 4'd8,
    DONE     = 4'd9
  } state_t;

  localparam logic [3:0] CARD_J = 4'd11;
  localparam logic [3:0] CARD_Q = 4'd12;
  localparam logic [3:0] CARD_K = 4'd13;

  localparam int NATURAL_MIN = 8;

  // Baccarat point value of a raw card code; tens, faces and invalid codes count as 0.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    logic [3:0] v;
    case (code)
      4'd10, CARD_J, CARD_Q, CARD_K: v = 4'd0;
      4'd0, 4'd14, 4'd15:            v = 4'd0;
      default:                       v = code;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card rule: decides whether the dealer draws given its score
// and the value (0-9) of the player's third card.
module banker_draw_rule #(
  parameter int SCORE_W = 4
) (
  input  logic [SCORE_W-1:0] dscore,
  input  logic [3:0]         pvalue,
  output logic               draw
);

  // Rule table indexed by dealer score.
  always_comb begin
    draw = 1'b0;
    case (dscore)
      SCORE_W'(0), SCORE_W'(1), SCORE_W'(2): draw = 1'b1;
      SCORE_W'(3): draw = (pvalue != 4'd8);
      SCORE_W'(4): draw = (pvalue >= 4'd2) && (pvalue <= 4'd7);
      SCORE_W'(5): draw = (pvalue >= 4'd4) && (pvalue <= 4'd7);
      SCORE_W'(6): draw = (pvalue >= 4'd6) && (pvalue <= 4'd7);
      default:     draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// Sequencing controller for one baccarat hand: deals cards on step pulses,
// applies natural and third-card rules, then latches the win lights.
module baccarat_deal_ctrl
  import baccarat_pkg::*;
#(
  parameter int SCORE_W = 4,
  parameter int CARD_W  = 4
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               step,
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [CARD_W-1:0]  pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               hand_done
);

  state_t     state;
  state_t     state_next;
  logic       banker_draw;
  logic       natural;
  logic [3:0] p3_value;

  assign p3_value = card_value(pcard3);
  assign natural  = (pscore >= SCORE_W'(NATURAL_MIN)) || (dscore >= SCORE_W'(NATURAL_MIN));

  banker_draw_rule #(.SCORE_W(SCORE_W)) u_rule (
    .dscore (dscore),
    .pvalue (p3_value),
    .draw   (banker_draw)
  );

  // Next-state selection: deal states wait for step, check states take one cycle.
  always_comb begin
    state_next = state;
    case (state)
      DEAL_P1:  if (step) state_next = DEAL_D1;
      DEAL_D1:  if (step) state_next = DEAL_P2;
      DEAL_P2:  if (step) state_next = DEAL_D2;
      DEAL_D2:  if (step) state_next = CHK_NAT;
      CHK_NAT: begin
        if (natural)                        state_next = RESULT;
        else if (pscore <= SCORE_W'(5))     state_next = DEAL_P3;
        else if (dscore <= SCORE_W'(5))     state_next = DEAL_D3;
        else                                state_next = RESULT;
      end
      DEAL_P3:  if (step) state_next = CHK_BANK;
      CHK_BANK: state_next = banker_draw ? DEAL_D3 : RESULT;
      DEAL_D3:  if (step) state_next = RESULT;
      RESULT:   state_next = DONE;
      DONE:     state_next = DONE;
      default:  state_next = DEAL_P1;
    endcase
  end

  // Load strobes: one per deal state, only while step is high; reset suppresses them.
  always_comb begin
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    if (resetb && step) begin
      case (state)
        DEAL_P1: load_pcard1 = 1'b1;
        DEAL_D1: load_dcard1 = 1'b1;
        DEAL_P2: load_pcard2 = 1'b1;
        DEAL_D2: load_dcard2 = 1'b1;
        DEAL_P3: load_pcard3 = 1'b1;
        DEAL_D3: load_dcard3 = 1'b1;
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= DEAL_P1;
    else         state <= state_next;
  end

  // Result lights and done flag, captured on leaving RESULT and held until reset.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      hand_done        <= 1'b0;
    end else if (state == RESULT) begin
      player_win_light <= (pscore >= dscore);
      dealer_win_light <= (dscore >= pscore);
      hand_done        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Directed, table-driven bench for the baccarat hand controller.
module tb_baccarat_deal_ctrl;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic       step       = 1'b0;
  logic [3:0] pscore     = '0;
  logic [3:0] dscore     = '0;
  logic [3:0] pcard3     = '0;
  logic load_pcard1, load_pcard2, load_pcard3;
  logic load_dcard1, load_dcard2, load_dcard3;
  logic player_win_light, dealer_win_light, hand_done;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] S_P1 = 6'b100000;
  localparam logic [5:0] S_D1 = 6'b010000;
  localparam logic [5:0] S_P2 = 6'b001000;
  localparam logic [5:0] S_D2 = 6'b000100;
  localparam logic [5:0] S_P3 = 6'b000010;
  localparam logic [5:0] S_D3 = 6'b000001;

  logic [5:0] deal_order [4];

  typedef struct {
    int pn; int dn; int pc3; int pf; int df;
    bit p3; bit d3; bit pl; bit dl;
  } vec_t;

  vec_t tbl [10];

  baccarat_deal_ctrl #(.SCORE_W(4), .CARD_W(4)) dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .step             (step),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .hand_done        (hand_done)
  );

  always #5 slow_clock = ~slow_clock;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [5:0] strobes();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive step after the falling edge, sample strobes before the rising edge.
  task automatic cyc(input logic s, output logic [5:0] st);
    @(negedge slow_clock);
    step = s;
    #1 st = strobes();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge slow_clock);
    step   = 1'b0;
    resetb = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  task automatic deal_four(input string tag);
    logic [5:0] st;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, st);
      chk($sformatf("%s_deal%0d", tag, i), int'(st), int'(deal_order[i]));
    end
  endtask

  // Plays a hand with step held high after the initial deal; the bench plays the datapath.
  task automatic run_hand(input vec_t v, input string tag, output logic [5:0] seen, output int done_at);
    logic [5:0] st;
    do_reset();
    pscore = 4'(v.pn);
    dscore = 4'(v.dn);
    pcard3 = '0;
    deal_four(tag);
    seen    = '0;
    done_at = -1;
    for (int c = 1; c <= 12 && done_at < 0; c++) begin
      cyc(1'b1, st);
      seen = seen | st;
      if (st[1]) begin
        pscore = 4'(v.pf);
        pcard3 = 4'(v.pc3);
      end
      if (st[0]) dscore = 4'(v.df);
      if (hand_done) done_at = c;
    end
  endtask

  // Banker rule as a value mask per dealer score.
  function automatic bit exp_draw(input int ds, input int code);
    logic [9:0] mask;
    logic [9:0] one_hot;
    int val;
    val = (code >= 1 && code <= 9) ? code : 0;
    case (ds)
      0, 1, 2: mask = 10'h3FF;
      3:       mask = 10'h2FF;
      4:       mask = 10'h0FC;
      5:       mask = 10'h0F0;
      6:       mask = 10'h0C0;
      default: mask = 10'h000;
    endcase
    one_hot = 10'(1) << val;
    return (mask & one_hot) != 0;
  endfunction

  initial begin
    logic [5:0] seen;
    logic [5:0] st;
    int done_at;
    int hold_hits;

    deal_order[0] = S_P1;
    deal_order[1] = S_D1;
    deal_order[2] = S_P2;
    deal_order[3] = S_D2;

    //            pn dn pc3 pf df  p3 d3 pl dl
    tbl[0] = '{8, 3, 0,  8, 3, 0, 0, 1, 0};  // player natural
    tbl[1] = '{5, 6, 6,  1, 9, 1, 1, 0, 1};  // both draw
    tbl[2] = '{7, 4, 0,  7, 7, 0, 1, 1, 1};  // player stands, dealer draws, tie
    tbl[3] = '{3, 3, 8,  1, 3, 1, 0, 0, 1};  // banker stands on 3 vs 8
    tbl[4] = '{3, 3, 12, 3, 2, 1, 1, 1, 0};  // queen counts 0, banker draws
    tbl[5] = '{6, 7, 0,  6, 7, 0, 0, 0, 1};  // both stand
    tbl[6] = '{2, 9, 0,  2, 9, 0, 0, 0, 1};  // dealer natural
    tbl[7] = '{2, 5, 14, 6, 5, 1, 0, 1, 0};  // invalid code 14 counts 0
    tbl[8] = '{5, 5, 13, 5, 5, 1, 0, 1, 1};  // king counts 0, tie
    tbl[9] = '{9, 9, 0,  9, 9, 0, 0, 1, 1};  // double natural tie

    // Reset state
    resetb = 1'b0;
    #3;
    chk("reset_strobes", int'(strobes()), 0);
    chk("reset_lights", int'({player_win_light, dealer_win_light, hand_done}), 0);

    // Table-driven hands
    for (int i = 0; i < 10; i++) begin
      run_hand(tbl[i], $sformatf("v%0d", i), seen, done_at);
      chk($sformatf("v%0d_p3", i), int'(seen[1]), int'(tbl[i].p3));
      chk($sformatf("v%0d_d3", i), int'(seen[0]), int'(tbl[i].d3));
      chk($sformatf("v%0d_extra", i), int'(seen[5:2]), 0);
      chk($sformatf("v%0d_done_lat", i), done_at, 2 + (tbl[i].p3 ? 2 : 0) + (tbl[i].d3 ? 1 : 0));
      chk($sformatf("v%0d_plight", i), int'(player_win_light), int'(tbl[i].pl));
      chk($sformatf("v%0d_dlight", i), int'(dealer_win_light), int'(tbl[i].dl));
      seen = '0;
      for (int k = 0; k < 3; k++) begin
        cyc(1'b1, st);
        seen = seen | st;
      end
      chk($sformatf("v%0d_done_quiet", i), int'(seen), 0);
      chk($sformatf("v%0d_done_hold", i),
          int'({player_win_light, dealer_win_light, hand_done}),
          int'({tbl[i].pl, tbl[i].dl, 1'b1}));
    end

    // Asynchronous reset while in DONE clears outputs without a clock edge
    @(posedge slow_clock);
    #2 resetb = 1'b0;
    #1;
    chk("async_reset_done", int'({player_win_light, dealer_win_light, hand_done}), 0);
    @(negedge slow_clock);
    resetb = 1'b1;

    // Reset mid-hand in DEAL_P3 with step high
    do_reset();
    pscore = 4'd3;
    dscore = 4'd3;
    deal_four("mid");
    cyc(1'b0, st);
    @(negedge slow_clock);
    step   = 1'b1;
    resetb = 1'b0;
    #1;
    chk("mid_reset_strobes", int'(strobes()), 0);
    chk("mid_reset_lights", int'({player_win_light, dealer_win_light, hand_done}), 0);
    @(negedge slow_clock);
    step   = 1'b0;
    resetb = 1'b1;
    deal_four("after_reset");

    // Step held low in deal states
    do_reset();
    hold_hits = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b0, st);
      if (st != 0) hold_hits++;
    end
    chk("hold_p1_quiet", hold_hits, 0);
    cyc(1'b1, st);
    chk("hold_p1_then", int'(st), int'(S_P1));
    cyc(1'b1, st);
    chk("hold_d1", int'(st), int'(S_D1));
    hold_hits = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b0, st);
      if (st != 0) hold_hits++;
    end
    chk("hold_p2_quiet", hold_hits, 0);
    cyc(1'b1, st);
    chk("hold_p2_then", int'(st), int'(S_P2));

    // Exhaustive banker rule through the controller
    for (int ds = 0; ds < 8; ds++) begin
      for (int c = 1; c <= 13; c++) begin
        vec_t v;
        v = '{3, ds, c, 3, ds, 1, 0, 0, 0};
        run_hand(v, $sformatf("rule_d%0d_c%0d", ds, c), seen, done_at);
        chk($sformatf("rule_d%0d_c%0d", ds, c), int'(seen[0]), int'(exp_draw(ds, c)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
